tt_um_accelshark_psg_i2s_tx: RTL and testbench
==============================================

// Module: tt_um_accelshark_psg_i2s_tx
// PURPOSE
//  Serial audio transmitter at the output end of the PSG voice/mix path.
//  - Captures one signed 16-bit stereo pair (mix_l/mix_r, two's complement) per frame.
//  - Shifts the pair out in standard I2S format: 32 BCLK per frame, 16 bits per channel, MSB first,
//    data delayed one BCLK after the LRCLK edge, LRCLK low = left.
//  - Drives an external I2S DAC from the summed voice mix.
// PARAMETERS
//  BCLK_DIV  8  clk cycles per BCLK period; even, >= 2. Frame = 32*BCLK_DIV clk cycles.
// PORTS
//  clk            in   1   system clock; single clock domain
//  rst            in   1   synchronous reset, active-high
//  ena            in   1   enable; low holds the block idle
//  mix_l          in   16  left sample, signed; sampled only at frame capture
//  mix_r          in   16  right sample, signed; sampled only at frame capture
//  i2s_bclk       out  1   bit clock, registered
//  i2s_lrclk      out  1   word select, registered; 0 = left, 1 = right
//  i2s_sdata      out  1   serial data, registered; changes only with BCLK falling
//  sample_strobe  out  1   one-clk pulse on the edge mix_l/mix_r are captured
// BEHAVIOUR
//  Reset state and ena=0 state (rst wins, both synchronous):
//  - div_cnt=0, bit_cnt=31, sh[31:0]=0.
//  - i2s_bclk = i2s_lrclk = i2s_sdata = sample_strobe = 0.
//  - ena=0 holds this state every cycle. Dropping ena mid-frame aborts the frame; outputs are 0 on the next clk.
//  Divider, ena=1:
//  - div_cnt counts 0..BCLK_DIV-1, then wraps.
//  - i2s_bclk <= (div_cnt_next >= BCLK_DIV/2), so BCLK is low in the first half of each period.
//  - The wrap BCLK_DIV-1 -> 0 is the "fall event".
//  Every fall event, all on the same clk edge:
//  - bit_cnt <= bit_cnt+1 (mod 32).
//  - i2s_lrclk <= bit_cnt_next[4].
//  - i2s_sdata <= sh[31].
//  - If bit_cnt_next != 0: sh <= sh << 1.
//  - If bit_cnt_next == 0: sh <= {mix_l, mix_r}, sample_strobe <= 1 for exactly this cycle.
//  Resulting slot map within a frame:
//  - slot 0: R bit0 of the previous frame (0 in the first frame after reset/enable).
//  - slots 1..16: L bits 15..0.
//  - slots 17..31: R bits 15..1.
//  - LRCLK is 0 in slots 0..15 and 1 in slots 16..31.
//  Timing:
//  - First fall event after reset/enable occurs BCLK_DIV clks after ena=1 is seen; it is also the first capture.
//  - Capture-to-first-MSB latency: 1 BCLK period.
//  - sample_strobe period: 32*BCLK_DIV clks, steady state.
//  - mix inputs changing between captures have no effect until the next capture; no input buffering or handshake.
//  - The receiver samples sdata on BCLK rising. sdata is stable from one falling edge to the next.
// STRUCTURE
//  Shared defines header:
//  - PSG_SAMPLE_W=16, PSG_I2S_FRAME_BITS=32.
//  - Slot constants: left-MSB slot=1, right-MSB slot=17.
//  Sub-module tt_um_accelshark_psg_bclk_gen:
//  - Contains div_cnt; outputs registered bclk and a one-clk fall_evt.
//  - Has clk/rst/ena ports and the BCLK_DIV parameter.
//  Top level holds bit_cnt, sh, lrclk, sdata and strobe.
// TESTING (BCLK_DIV=4; bench samples sdata/lrclk at each bclk rise)
//  1. rst=1 for 3 clks, ena=1 -> all outputs 0; no strobe while rst is high.
//  2. ena=1, mix_l=16'hA5C3, mix_r=16'h0F0F:
//     - 2nd frame slots 1..16 read 16'hA5C3, slots 17..31 + next slot 0 read 16'h0F0F.
//     - lrclk pattern is 16x0 then 16x1.
//  3. Signed extremes, mix_l=16'h8000, mix_r=16'h7FFF:
//     - L serial = 1 then fifteen 0s; R serial = 0 then fifteen 1s.
//     - sample_strobe pulses exactly every 128 clks.
//  4. Change mix_l from 16'h1234 to 16'hFFFF mid-frame (slot 8):
//     - Current frame still transmits 16'h1234.
//     - The frame after the next strobe transmits 16'hFFFF.
//  5. ena=0 at slot 20:
//     - Next clk: bclk, lrclk, sdata = 0 and no strobe, held while ena stays low.
//     - Re-enable: first strobe exactly 4 clks later; slot 0 sdata = 0.
//  6. rst=1 for one clk at slot 10 with ena=1:
//     - Outputs 0 on the next clk.
//     - Next strobe 4 clks after rst deasserts; frame realigned.

Source files
------------

// File: rtl/tt_um_accelshark_psg_i2s_tx_pkg.sv
// Shared widths, slot constants and the stereo
// sample bundle for the PSG I2S transmitter.
package tt_um_accelshark_psg_i2s_tx_pkg;

  localparam int PSG_SAMPLE_W       = 16;
  localparam int PSG_I2S_FRAME_BITS = 32;
  localparam int PSG_I2S_SLOT_W     = $clog2(PSG_I2S_FRAME_BITS);

  localparam logic [PSG_I2S_SLOT_W-1:0] SLOT_L_MSB = 5'd1;
  localparam logic [PSG_I2S_SLOT_W-1:0] SLOT_R_MSB = 5'd17;

  typedef struct packed {
    logic signed [PSG_SAMPLE_W-1:0] l;
    logic signed [PSG_SAMPLE_W-1:0] r;
  } psg_pair_t;

endpackage

// File: rtl/tt_um_accelshark_psg_bclk_gen.sv
// BCLK divider: registered bit clock plus a one-clk
// fall event on the divider wrap.
module tt_um_accelshark_psg_bclk_gen #(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic bclk,
  output logic fall_evt
);

  localparam int W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(BCLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(BCLK_DIV / 2);

  logic [W-1:0] div_cnt;
  logic [W-1:0] div_nxt;

  assign div_nxt  = (div_cnt == LAST) ? '0 : div_cnt + W'(1);
  assign fall_evt = ena && !rst && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bclk    <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/tt_um_accelshark_psg_i2s_tx.sv
// I2S transmitter: captures one stereo pair per frame
// and shifts it out MSB first, one BCLK after LRCLK.
module tt_um_accelshark_psg_i2s_tx
  import tt_um_accelshark_psg_i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] mix_l,
  input  logic [15:0] mix_r,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_strobe
);

  logic                      fall_evt;
  logic [PSG_I2S_SLOT_W-1:0] bit_cnt;
  logic [PSG_I2S_SLOT_W-1:0] bit_nxt;
  logic [31:0]               sh;
  psg_pair_t                 pair;

  tt_um_accelshark_psg_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .bclk    (i2s_bclk),
    .fall_evt(fall_evt)
  );

  assign pair    = '{l: mix_l, r: mix_r};
  assign bit_nxt = bit_cnt + 5'd1;

  // Slot 0 carries the previous R LSB, so capture and
  // the last shift-out happen on the same fall event.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      bit_cnt       <= 5'd31;
      sh            <= '0;
      i2s_lrclk     <= 1'b0;
      i2s_sdata     <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (fall_evt) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[PSG_I2S_SLOT_W-1];
        i2s_sdata <= sh[31];
        if (bit_nxt == '0) begin
          sh            <= pair;
          sample_strobe <= 1'b1;
        end else begin
          sh <= {sh[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_accelshark_psg_i2s_tx.sv
// Directed bench for the PSG I2S transmitter at
// BCLK_DIV=4, sampling on the clk falling edge.
module tb_tt_um_accelshark_psg_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] mix_l = '0;
  logic [15:0] mix_r = '0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_strobe;

  int tests = 0;
  int fails = 0;
  logic sd [0:40];
  logic lr [0:40];

  tt_um_accelshark_psg_i2s_tx #(
    .BCLK_DIV(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .mix_l        (mix_l),
    .mix_r        (mix_r),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {i2s_bclk, i2s_lrclk, i2s_sdata,
            sample_strobe};
  endfunction

  function automatic logic [15:0] pack16(input int s);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = sd[s+i];
    return r;
  endfunction

  function automatic logic [31:0] lr_pat(input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = lr[s+i];
    return r;
  endfunction

  task automatic next_rise(output logic got);
    int   n;
    logic prev;
    prev = i2s_bclk;
    n    = 0;
    got  = 1'b0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      got  = i2s_bclk && !prev;
      prev = i2s_bclk;
    end
  endtask

  // Record sdata/lrclk at n BCLK rises into slots start..
  task automatic get_slots(input int n, input int start);
    logic got;
    for (int i = 0; i < n; i++) begin
      next_rise(got);
      if (!got) chk("bclk_rise_timeout", 32'(got), 32'd1);
      sd[start+i] = i2s_sdata;
      lr[start+i] = i2s_lrclk;
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_strobe && n < 300);
    if (!sample_strobe)
      chk("strobe_timeout", 32'(sample_strobe), 32'd1);
  endtask

  initial begin
    int n;
    // 1: reset with ena high
    mix_l = 16'hA5C3;
    mix_r = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'd0);
    end
    rst = 1'b0;

    // 2: first frame after reset
    wait_strobe(n);
    chk("first_strobe_lat", n, 4);
    get_slots(33, 0);
    chk("t2_slot0", 32'(sd[0]), 32'd0);
    chk("t2_left", 32'(pack16(1)), 32'h0000A5C3);
    chk("t2_right", 32'(pack16(17)), 32'h00000F0F);
    chk("t2_lrclk", lr_pat(0), 32'h0000FFFF);

    // 3: signed extremes and strobe period
    mix_l = 16'h8000;
    mix_r = 16'h7FFF;
    wait_strobe(n);
    wait_strobe(n);
    chk("strobe_period", n, 128);
    get_slots(33, 0);
    chk("t3_slot0", 32'(sd[0]), 32'd1);
    chk("t3_left", 32'(pack16(1)), 32'h00008000);
    chk("t3_right", 32'(pack16(17)), 32'h00007FFF);

    // 4: mid-frame change waits for next capture
    mix_l = 16'h1234;
    wait_strobe(n);
    get_slots(9, 0);
    mix_l = 16'hFFFF;
    get_slots(24, 9);
    chk("t4_cur_left", 32'(pack16(1)), 32'h00001234);
    chk("t4_cur_right", 32'(pack16(17)), 32'h00007FFF);
    get_slots(32, 1);
    chk("t4_next_left", 32'(pack16(1)), 32'h0000FFFF);

    // 5: ena drop at slot 20
    get_slots(20, 1);
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ena_low_outs", 32'(outs()), 32'd0);
    end
    ena = 1'b1;
    wait_strobe(n);
    chk("reena_strobe_lat", n, 4);
    get_slots(1, 0);
    chk("reena_slot0", 32'({sd[0], lr[0]}), 32'd0);

    // 6: one-clk reset at slot 10
    get_slots(10, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    wait_strobe(n);
    chk("rst_strobe_lat", n, 4);
    get_slots(33, 0);
    chk("t6_slot0", 32'(sd[0]), 32'd0);
    chk("t6_left", 32'(pack16(1)), 32'h0000FFFF);
    chk("t6_right", 32'(pack16(17)), 32'h00007FFF);
    chk("t6_lrclk", lr_pat(0), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
